// File: rtl/dac_spi_driver.sv
// dac_spi_driver
// Serialises 12-bit unsigned samples as 16-bit frames {4'b0000, sample} for a
// DAC121S101-class converter (Pmod DA2). MSB first, SCLK idles high, DIN only
// changes on SCLK rising edges, so the DAC samples stable data on the falling edge.
// Build option: define DAC_DUAL_EN to add a second data line (DATA_B -> DIN_B)
// shifted in lockstep with DIN and sharing SCLK/SYNC_N.
module dac_spi_driver #(
    parameter int unsigned CLK_DIV    = 2,  // system clocks per SCLK half-period, 1..255
    parameter int unsigned GAP_CYCLES = 4   // SYNC_N high time after a frame, 1..255
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [11:0] DATA,
    input  logic        VALID,
    output logic        READY,
    output logic        SCLK,
    output logic        SYNC_N,
    output logic        DIN,
`ifdef DAC_DUAL_EN
    input  logic [11:0] DATA_B,
    output logic        DIN_B,
`endif
    output logic        DONE
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 32'd1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 32'd1);
    localparam logic [3:0] LAST_BIT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] shift_r;
    logic [7:0]  div_r;
    logic [3:0]  bit_cnt_r;
    logic [7:0]  gap_cnt_r;
    logic        ready_r;
    logic        sclk_r;
    logic        sync_n_r;
    logic        done_r;

    logic        accept_s;
    logic        phase_end_s;
    logic        rise_s;
    logic        frame_end_s;

    // Decode handshake acceptance and the end of each SCLK half-period.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && ready_r && VALID;
        phase_end_s = (state_r == ST_SHIFT) && (div_r == DIV_LAST);
        rise_s      = phase_end_s && !sclk_r && (bit_cnt_r != LAST_BIT);
        frame_end_s = phase_end_s && !sclk_r && (bit_cnt_r == LAST_BIT);
    end

    // Frame sequencer: latch a sample, pace the SCLK phases, then hold the gap.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            shift_r   <= 16'h0000;
            div_r     <= 8'd0;
            bit_cnt_r <= 4'd0;
            gap_cnt_r <= 8'd0;
            ready_r   <= 1'b1;
            sclk_r    <= 1'b1;
            sync_n_r  <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        // Bits 15:12 are zero: two don't-care bits plus normal-operation mode.
                        state_r   <= ST_SHIFT;
                        shift_r   <= {4'b0000, DATA};
                        div_r     <= 8'd0;
                        bit_cnt_r <= 4'd0;
                        ready_r   <= 1'b0;
                        sync_n_r  <= 1'b0;
                        sclk_r    <= 1'b1;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (frame_end_s) begin
                        // Closing rise of the 16th bit coincides with SYNC_N rising.
                        state_r   <= ST_GAP;
                        shift_r   <= 16'h0000;
                        div_r     <= 8'd0;
                        bit_cnt_r <= 4'd0;
                        gap_cnt_r <= 8'd0;
                        sclk_r    <= 1'b1;
                        sync_n_r  <= 1'b1;
                        done_r    <= 1'b1;
                    end else if (rise_s) begin
                        shift_r   <= {shift_r[14:0], 1'b0};
                        div_r     <= 8'd0;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        sclk_r    <= 1'b1;
                    end else if (phase_end_s) begin
                        div_r  <= 8'd0;
                        sclk_r <= 1'b0;
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    shift_r   <= 16'h0000;
                    div_r     <= 8'd0;
                    bit_cnt_r <= 4'd0;
                    gap_cnt_r <= 8'd0;
                    ready_r   <= 1'b1;
                    sclk_r    <= 1'b1;
                    sync_n_r  <= 1'b1;
                end
            endcase
        end
    end

`ifdef DAC_DUAL_EN
    logic [15:0] shift_b_r;

    // Channel B shift register, loaded and advanced on the same strobes as channel A.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shift_b_r <= 16'h0000;
        end else if (accept_s) begin
            shift_b_r <= {4'b0000, DATA_B};
        end else if (rise_s) begin
            shift_b_r <= {shift_b_r[14:0], 1'b0};
        end else if (frame_end_s || (state_r != ST_SHIFT)) begin
            shift_b_r <= 16'h0000;
        end else begin
            shift_b_r <= shift_b_r;
        end
    end

    assign DIN_B = shift_b_r[15];
`endif

    // Every output is a flop (DIN is the MSB of the shift register).
    assign READY  = ready_r;
    assign SCLK   = sclk_r;
    assign SYNC_N = sync_n_r;
    assign DIN    = shift_r[15];
    assign DONE   = done_r;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: table-driven frames plus hand-written timing,
// back-to-back, busy-drop, reset-abort and minimum-parameter sequences.
// Instance u_dut uses defaults (CLK_DIV=2, GAP_CYCLES=4); u_dut_fast uses 1/1.
module tb_dac_spi_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [11:0] data0, data1;
    logic        valid0, valid1;
    logic        ready0, sclk0, sync_n0, din0, done0;
    logic        ready1, sclk1, sync_n1, din1, done1;
    logic        din_b0, din_b1;
`ifdef DAC_DUAL_EN
    localparam bit DUAL = 1'b1;
    logic [11:0] data_b0, data_b1;
`else
    localparam bit DUAL = 1'b0;
    assign din_b0 = 1'b0;
    assign din_b1 = 1'b0;
`endif

    dac_spi_driver #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut (
        .CLK(clk), .RESET_N(rst_n), .DATA(data0), .VALID(valid0), .READY(ready0),
        .SCLK(sclk0), .SYNC_N(sync_n0), .DIN(din0),
`ifdef DAC_DUAL_EN
        .DATA_B(data_b0), .DIN_B(din_b0),
`endif
        .DONE(done0)
    );

    dac_spi_driver #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut_fast (
        .CLK(clk), .RESET_N(rst_n), .DATA(data1), .VALID(valid1), .READY(ready1),
        .SCLK(sclk1), .SYNC_N(sync_n1), .DIN(din1),
`ifdef DAC_DUAL_EN
        .DATA_B(data_b1), .DIN_B(din_b1),
`endif
        .DONE(done1)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {chan B word, chan A word}; captured {glitch, B, A}.
    logic [31:0] sb0[$], sb1[$];
    logic [32:0] cap0[$], cap1[$];

    typedef struct {
        logic [11:0] data_a;
        logic [11:0] data_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;
    vec_t vec [6];

    // Frame monitor: sample the data lines whenever SCLK is seen falling inside a frame.
    logic [15:0] wa0 = 16'h0, wb0 = 16'h0, wa1 = 16'h0, wb1 = 16'h0;
    int nb0 = 0, nb1 = 0;
    logic sp0 = 1'b1, sp1 = 1'b1, dp0 = 1'b0, dp1 = 1'b0, dbp0 = 1'b0, dbp1 = 1'b0;
    logic gl0 = 1'b0, gl1 = 1'b0;
    always @(negedge clk) begin
        if (sync_n0 !== 1'b0) begin
            nb0 = 0; gl0 = 1'b0;
        end else if (sp0 && !sclk0) begin
            wa0 = {wa0[14:0], din0}; wb0 = {wb0[14:0], din_b0}; nb0++;
            if (nb0 == 16) cap0.push_back({gl0, wb0, wa0});
        end else if (!sp0 && !sclk0 && ((din0 !== dp0) || (din_b0 !== dbp0))) begin
            gl0 = 1'b1;
        end
        if (sync_n1 !== 1'b0) begin
            nb1 = 0; gl1 = 1'b0;
        end else if (sp1 && !sclk1) begin
            wa1 = {wa1[14:0], din1}; wb1 = {wb1[14:0], din_b1}; nb1++;
            if (nb1 == 16) cap1.push_back({gl1, wb1, wa1});
        end else if (!sp1 && !sclk1 && ((din1 !== dp1) || (din_b1 !== dbp1))) begin
            gl1 = 1'b1;
        end
        sp0 = sclk0; dp0 = din0; dbp0 = din_b0;
        sp1 = sclk1; dp1 = din1; dbp1 = din_b1;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int w);  return (w == 0) ? ready0  : ready1;  endfunction
    function automatic logic snc(input int w);  return (w == 0) ? sync_n0 : sync_n1; endfunction
    function automatic logic sck(input int w);  return (w == 0) ? sclk0   : sclk1;   endfunction
    function automatic logic dn(input int w);   return (w == 0) ? done0   : done1;   endfunction

    task automatic set_in(input int w, input logic v, input logic [11:0] d, input logic [11:0] db);
        if (w == 0) begin
            valid0 = v; data0 = d;
`ifdef DAC_DUAL_EN
            data_b0 = db;
`endif
        end else begin
            valid1 = v; data1 = d;
`ifdef DAC_DUAL_EN
            data_b1 = db;
`endif
        end
        if (db === 12'hxxx) $display("note: undefined channel B data");
    endtask

    // Offer a sample, wait for READY, queue the expectation, return just after the accept edge.
    task automatic start(input int w, input logic [11:0] d, input logic [11:0] db,
                         input logic [31:0] exp, input bit push);
        int budget = 0;
        @(negedge clk);
        set_in(w, 1'b1, d, db);
        while (!rdy(w) && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        chk("start_ready", rdy(w), 1'b1);
        if (push) begin
            if (w == 0) sb0.push_back(exp);
            else        sb1.push_back(exp);
        end
        @(posedge clk);
    endtask

    task automatic wait_done(input int w);
        int budget = 0;
        while (!dn(w) && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        chk("done_seen", dn(w), 1'b1);
        @(negedge clk);
    endtask

    task automatic check_frame(input int w, input string name);
        logic [32:0] c;
        logic [31:0] e;
        c = {1'b1, 32'hFFFF_FFFF};
        e = 32'h0000_0000;
        if (w == 0) begin
            if (cap0.size() > 0) c = cap0.pop_front();
            if (sb0.size() > 0)  e = sb0.pop_front();
        end else begin
            if (cap1.size() > 0) c = cap1.pop_front();
            if (sb1.size() > 0)  e = sb1.pop_front();
        end
        chk(name, {7'd0, c}, {8'd0, e});
    endtask

    // Single frame with cycle-accurate timing measurements relative to the accept edge.
    task automatic frame_timing(input int w, input logic [11:0] d, input logic [15:0] exp_a,
                                input int exp_low_last, input int exp_done, input int exp_ready,
                                input int exp_fall_first, input int exp_fall_last, input int n_total);
        int low_first = -1, low_last = -1, low_cnt = 0;
        int done_first = -1, done_cnt = 0, rdy_first = -1;
        int fall_first = -1, fall_last = -1, fall_cnt = 0;
        logic sclk_prev = 1'b1;
        start(w, d, 12'h000, {16'h0000, exp_a}, 1'b1);
        for (int n = 1; n <= n_total; n++) begin
            @(negedge clk);
            if (n == 1) set_in(w, 1'b0, ~d, 12'h000);
            if (!snc(w)) begin
                if (low_first < 0) low_first = n;
                low_last = n;
                low_cnt++;
            end
            if (dn(w)) begin
                if (done_first < 0) done_first = n;
                done_cnt++;
            end
            if (rdy(w) && rdy_first < 0) rdy_first = n;
            if (sclk_prev && !sck(w)) begin
                if (fall_first < 0) fall_first = n;
                fall_last = n;
                fall_cnt++;
            end
            sclk_prev = sck(w);
        end
        chk("sync_low_first", low_first, 1);
        chk("sync_low_last", low_last, exp_low_last);
        chk("sync_low_count", low_cnt, exp_low_last);
        chk("done_cycle", done_first, exp_done);
        chk("done_pulse_count", done_cnt, 1);
        chk("ready_return", rdy_first, exp_ready);
        chk("first_fall", fall_first, exp_fall_first);
        chk("last_fall", fall_last, exp_fall_last);
        chk("fall_count", fall_cnt, 16);
    endtask

    initial begin
        int acc2;
        int hi_gap;
        vec[0] = '{12'hABC, 12'h123, 16'h0ABC, 16'h0123};
        vec[1] = '{12'h000, 12'hFFF, 16'h0000, 16'h0FFF};
        vec[2] = '{12'hFFF, 12'h000, 16'h0FFF, 16'h0000};
        vec[3] = '{12'h800, 12'h001, 16'h0800, 16'h0001};
        vec[4] = '{12'h5A5, 12'h3C3, 16'h05A5, 16'h03C3};
        vec[5] = '{12'h001, 12'h800, 16'h0001, 16'h0800};

        rst_n = 1'b0;
        set_in(0, 1'b0, 12'h000, 12'h000);
        set_in(1, 1'b0, 12'h000, 12'h000);
        repeat (3) @(negedge clk);
        chk("reset_ready", ready0, 1'b1);
        chk("reset_sclk", sclk0, 1'b1);
        chk("reset_sync_n", sync_n0, 1'b1);
        chk("reset_din", din0, 1'b0);
        chk("reset_din_b", din_b0, 1'b0);
        chk("reset_done", done0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame at defaults: low 1..64, DONE 65, READY 69, falls at 3..63.
        frame_timing(0, 12'hABC, 16'h0ABC, 64, 65, 69, 3, 63, 72);
        check_frame(0, "single_frame_abc");

        // Table of samples through the scoreboard.
        for (int i = 0; i < 6; i++) begin
            start(0, vec[i].data_a, vec[i].data_b,
                  {(DUAL ? vec[i].exp_b : 16'h0000), vec[i].exp_a}, 1'b1);
            @(negedge clk);
            set_in(0, 1'b0, ~vec[i].data_a, ~vec[i].data_b);
            wait_done(0);
            check_frame(0, "table_frame");
        end

        // Back-to-back with VALID held: second accept 69 cycles later, 4 GAP cycles.
        start(0, 12'h000, 12'h000, 32'h0000_0000, 1'b1);
        acc2 = -1;
        hi_gap = 0;
        for (int n = 1; n <= 200 && acc2 < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                set_in(0, 1'b1, 12'hFFF, 12'h000);
                sb0.push_back({16'h0000, 16'h0FFF});
            end
            if (sync_n0 && !ready0) hi_gap++;
            if (ready0 && valid0) acc2 = n;
        end
        chk("b2b_period", acc2, 69);
        chk("b2b_gap_hold", hi_gap, 4);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 12'h000, 12'h000);
        wait_done(0);
        check_frame(0, "b2b_frame_1");
        check_frame(0, "b2b_frame_2");

        // Busy drop: VALID offered during cycles 10..20 of a frame is ignored.
        start(0, 12'h800, 12'h000, {16'h0000, 16'h0800}, 1'b1);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 1)  set_in(0, 1'b0, 12'h800, 12'h000);
            if (n == 10) set_in(0, 1'b1, 12'h123, 12'h000);
            if (n == 15) chk("busy_ready_low", ready0, 1'b0);
            if (n == 21) set_in(0, 1'b0, 12'h123, 12'h000);
        end
        wait_done(0);
        repeat (80) @(negedge clk);
        chk("busy_frame_count", cap0.size(), 1);
        check_frame(0, "busy_frame");
        chk("busy_idle_ready", ready0, 1'b1);

        // Reset mid-frame at cycle 20: outputs return to idle without a clock edge.
        start(0, 12'hC56, 12'h000, 32'h0000_0000, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) set_in(0, 1'b0, 12'h000, 12'h000);
        end
        chk("pre_reset_sync_n", sync_n0, 1'b0);
        chk("pre_reset_sclk", sclk0, 1'b0);
        chk("pre_reset_din", din0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_ready", ready0, 1'b1);
        chk("async_reset_sync_n", sync_n0, 1'b1);
        chk("async_reset_sclk", sclk0, 1'b1);
        chk("async_reset_din", din0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_frame", cap0.size(), 0);
        start(0, 12'h3C3, 12'h5A5, {(DUAL ? 16'h05A5 : 16'h0000), 16'h03C3}, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 12'h000, 12'h000);
        wait_done(0);
        check_frame(0, "post_reset_frame");

        // Minimum parameters: low 1..32, DONE 33, READY 34, falls at 2..32.
        frame_timing(1, 12'h001, 16'h0001, 32, 33, 34, 2, 32, 37);
        check_frame(1, "edge_param_frame");

`ifdef DAC_DUAL_EN
        // Both channels sampled on the same falling edges.
        start(0, 12'h5A5, 12'h3C3, {16'h03C3, 16'h05A5}, 1'b1);
        @(negedge clk);
        set_in(0, 1'b0, 12'h000, 12'h000);
        wait_done(0);
        check_frame(0, "dual_frame");
`endif

        repeat (5) @(negedge clk);
        chk("sb0_empty", sb0.size(), 0);
        chk("sb1_empty", sb1.size(), 0);
        chk("cap0_empty", cap0.size(), 0);
        chk("cap1_empty", cap1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_spi_driver.md
# dac_spi_driver

Serial DAC driver that sits directly downstream of the sine-wave/waveform stage. Accepts 12-bit unsigned samples (0..4095, midscale 2048) over a valid/ready handshake and shifts each one out as a 16-bit SPI-style frame to a Pmod DA2 (DAC121S101-class) converter. Generates SCLK, SYNC_N and DIN from the single system clock, with a programmable SCLK rate and inter-frame gap.

## Interface
- CLK_DIV, 2: system clocks per SCLK half-period; legal range 1..255.
- GAP_CYCLES, 4: system clocks SYNC_N is held high after each frame; legal range 1..255.
- CLK  input  1  system clock; all logic on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- DATA  input  12  sample, channel A; unsigned.
- VALID  input  1  sample on DATA is offered.
- READY  output  1  driver can accept a sample this cycle.
- SCLK  output  1  serial clock to DAC; idles high.
- SYNC_N  output  1  frame select, active low.
- DIN  output  1  serial data, channel A.
- DONE  output  1  one-cycle pulse when a frame completes.
- DATA_B  input  12  channel B sample (only with DAC_DUAL_EN).
- DIN_B  output  1  serial data, channel B (only with DAC_DUAL_EN).

## Operation
- Reset values: READY=1, SCLK=1, SYNC_N=1, DIN=0, DIN_B=0, DONE=0; state IDLE; shift register, divider and bit counter cleared. Reset is applied asynchronously and aborts any frame in progress; the DAC discards the partial frame because SYNC_N rises before the 16th falling edge.
- States: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE: READY=1. Accept when VALID && READY at a rising edge: latch {4'b0000, DATA} into a 16-bit shift register and go to SHIFT. The two leading zeros are don't-care bits; bits 13:12 = 00 select normal operation (no power-down).
- SHIFT: READY=0. SYNC_N=0. DIN = shift[15], MSB first. Divider counts CLK_DIV cycles per SCLK phase. SCLK falls, DAC samples DIN, then SCLK rises and the shift register shifts left by 1, presenting the next bit. After the 16th falling edge and the following high phase, go to GAP.
- GAP: SYNC_N=1, SCLK=1, DIN=0. DONE pulses on the first GAP cycle. After GAP_CYCLES cycles, return to IDLE.
- VALID while READY=0 is ignored. There is no queue. Upstream holds VALID/DATA until accepted. DATA changes after acceptance do not affect the frame in flight.
- VALID held high continuously gives back-to-back frames at maximum rate.

## Timing
- Accept at edge 0. SYNC_N=0 and DIN=bit15 from cycle 1, with SCLK=1.
- Falling edge k (k=1..16) occurs at cycle 1+(2k-1)·CLK_DIV. DIN changes only when SCLK rises, never when it falls.
- SYNC_N is low for exactly 32·CLK_DIV cycles, from cycle 1 to cycle 32·CLK_DIV.
- SYNC_N rises and DONE pulses at cycle 1+32·CLK_DIV.
- READY returns at cycle 1+32·CLK_DIV+GAP_CYCLES, so the next accept can occur on that edge.
- Defaults: frame period 69 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- DAC_DUAL_EN defined: DATA_B is latched into a second shift register on the same accept edge. DIN_B is shifted in lockstep with DIN, sharing SCLK and SYNC_N, so both DAC chips update on the same frame. Reset and GAP value of DIN_B is 0.
- DAC_DUAL_EN undefined: the DATA_B and DIN_B ports and the second shift register are absent. Behaviour is otherwise identical.

## Test plan
- Single frame, defaults: DATA=12'hABC with VALID pulsed at cycle 0 -> DIN sampled on the 16 SCLK falling edges reads 0000_1010_1011_1100. SYNC_N is low for cycles 1..64. DONE pulses at cycle 65. READY rises at cycle 69.
- Back-to-back: VALID held high with DATA=12'h000 then 12'hFFF -> accepts at cycles 0 and 69. The second frame shifts out 0000_1111_1111_1111. SYNC_N is high for exactly 4 cycles between the frames.
- Busy drop: accept 12'h800, then present VALID with 12'h123 at cycles 10..20 only -> the second sample is never accepted. Only one frame (0000_1000_0000_0000) is emitted.
- Reset mid-frame: assert RESET_N=0 at cycle 20 of a frame -> SYNC_N=1, SCLK=1, DIN=0, READY=1 immediately, with no clock required. The first VALID after release starts a clean 16-bit frame.
- Edge parameters: CLK_DIV=1, GAP_CYCLES=1, DATA=12'h001 -> SYNC_N is low for 32 cycles. The last falling edge samples 1. READY returns at cycle 34.
- DAC_DUAL_EN: DATA=12'h5A5 and DATA_B=12'h3C3 -> DIN and DIN_B carry 0000_0101_1010_0101 and 0000_0011_1100_0011 on the same falling edges.
